// File: rtl/quad_enc_frontend.sv
// Quadrature encoder front end: input synchroniser, glitch filter, x4 decoder and
// rotating slot select used by the downstream moving-window pulse sum.
module quad_enc_frontend #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned FILT_LEN        = 4,
  parameter int unsigned LOG2_N_SUB_CTRS = 4,
  parameter int unsigned SLOT_CYCLES     = 100000,
  parameter int unsigned SLOT_CNT_W      = 17
) (
  input  logic                       CLK,
  input  logic                       wkctr_reset,
  input  logic                       ENC_A,
  input  logic                       ENC_B,
  input  logic                       EN,
  input  logic                       ERR_CLR,
  output logic                       INC,
  output logic                       DIR,
  output logic [LOG2_N_SUB_CTRS-1:0] SEL,
  output logic                       SLOT_TICK,
  output logic                       ERR,
  output logic [15:0]                POS
);

  localparam int unsigned SEL_W = LOG2_N_SUB_CTRS;
  localparam int unsigned POS_W = 16;
  localparam int unsigned FC_W  = $clog2(FILT_LEN + 1);

  localparam logic [SLOT_CNT_W-1:0] SLOT_LAST = SLOT_CNT_W'(SLOT_CYCLES - 1);
  localparam logic [FC_W-1:0]       FC_ACCEPT = FC_W'(FILT_LEN - 1);
  localparam logic [FC_W-1:0]       FC_FULL   = FC_W'(FILT_LEN);

  typedef enum logic {ST_INIT, ST_TRACK} state_e;

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  sync_c;
  logic [1:0]                  cand_q, cand_d;
  logic [FC_W-1:0]             cnt_q, cnt_d;
  logic [1:0]                  filt_q, filt_d;
  logic                        upd_q, upd_d;

  state_e                      state_q, state_d;
  logic [1:0]                  prev_q, prev_d;
  logic                        dir_q, dir_d;
  logic [POS_W-1:0]            pos_q, pos_d;
  logic                        err_q, err_d;
  logic                        inc_q, inc_d;
  logic                        pend_q, pend_d;
  logic [SLOT_CNT_W-1:0]       timer_q, timer_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic                        tick_q, tick_d;

  logic [1:0]                  delta_c;
  logic                        adv_c;
  logic                        step_c;
  logic                        err_set_c;

  // Position of a {A,B} code along the forward Gray cycle 00,01,11,10.
  function automatic logic [1:0] gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   gidx = 2'd0;
      2'b01:   gidx = 2'd1;
      2'b11:   gidx = 2'd2;
      default: gidx = 2'd3;
    endcase
  endfunction

  assign sync_c  = sync_q[SYNC_STAGES-1];
  assign delta_c = gidx(filt_q) - gidx(prev_q);
  assign adv_c   = EN && (timer_q == SLOT_LAST);

  // Filter: a level is accepted once, on the FILT_LEN-th consecutive equal sample.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    upd_d  = 1'b0;
    if (sync_c != cand_q) begin
      cand_d = sync_c;
      cnt_d  = FC_W'(1);
    end else if (cnt_q != FC_FULL) begin
      cnt_d = cnt_q + FC_W'(1);
      if (cnt_q == FC_ACCEPT) begin
        filt_d = cand_q;
        upd_d  = 1'b1;
      end
    end
  end

  // Decoder FSM, error flag, INC with deferral off the slot-advance cycle, slot timer.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    dir_d     = dir_q;
    pos_d     = pos_q;
    step_c    = 1'b0;
    err_set_c = 1'b0;
    inc_d     = 1'b0;
    pend_d    = 1'b0;
    timer_d   = timer_q;
    sel_d     = sel_q;
    tick_d    = 1'b0;

    if (upd_q) begin
      prev_d = filt_q;
      case (state_q)
        ST_INIT: state_d = ST_TRACK;
        default: begin
          case (delta_c)
            2'd1: begin
              step_c = 1'b1;
              dir_d  = 1'b1;
              pos_d  = pos_q + POS_W'(1);
            end
            2'd3: begin
              step_c = 1'b1;
              dir_d  = 1'b0;
              pos_d  = pos_q - POS_W'(1);
            end
            2'd2:    err_set_c = 1'b1;
            default: ;
          endcase
        end
      endcase
    end

    err_d = err_set_c ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);

    if (EN) begin
      if (step_c && adv_c) begin
        pend_d = 1'b1;
      end else if (step_c || pend_q) begin
        inc_d = 1'b1;
      end
      if (adv_c) begin
        timer_d = '0;
        sel_d   = sel_q + SEL_W'(1);
        tick_d  = 1'b1;
      end else begin
        timer_d = timer_q + SLOT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge wkctr_reset) begin
    if (wkctr_reset) begin
      sync_q  <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= '0;
      upd_q   <= 1'b0;
      state_q <= ST_INIT;
      prev_q  <= '0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
      err_q   <= 1'b0;
      inc_q   <= 1'b0;
      pend_q  <= 1'b0;
      timer_q <= '0;
      sel_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ENC_A, ENC_B};
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      upd_q   <= upd_d;
      state_q <= state_d;
      prev_q  <= prev_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      inc_q   <= inc_d;
      pend_q  <= pend_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  assign INC       = inc_q;
  assign DIR       = dir_q;
  assign SEL       = sel_q;
  assign SLOT_TICK = tick_q;
  assign ERR       = err_q;
  assign POS       = pos_q;

endmodule

// File: tb/tb_quad_enc_frontend.sv
// Bench for quad_enc_frontend: cycle model of the encoder front end checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_quad_enc_frontend;

  localparam int unsigned SLOT = 8;
  localparam int unsigned NSEL = 16;
  localparam int unsigned FL   = 4;

  logic        CLK = 1'b0;
  logic        wkctr_reset = 1'b1;
  logic        ENC_A = 1'b1;
  logic        ENC_B = 1'b1;
  logic        EN = 1'b1;
  logic        ERR_CLR = 1'b0;
  logic        INC, DIR, SLOT_TICK, ERR;
  logic [3:0]  SEL;
  logic [15:0] POS;

  quad_enc_frontend #(
    .SYNC_STAGES(2), .FILT_LEN(FL), .LOG2_N_SUB_CTRS(4),
    .SLOT_CYCLES(SLOT), .SLOT_CNT_W(4)
  ) dut (
    .CLK(CLK), .wkctr_reset(wkctr_reset), .ENC_A(ENC_A), .ENC_B(ENC_B),
    .EN(EN), .ERR_CLR(ERR_CLR), .INC(INC), .DIR(DIR), .SEL(SEL),
    .SLOT_TICK(SLOT_TICK), .ERR(ERR), .POS(POS)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  rawq[$];
  logic [1:0]  hist[$];
  int          nsamp, en_edges, delayed, inc_seen, tick_seen;
  bit          acc_pend, tracking, inc_next;
  logic [1:0]  acc_val, last, raw, s;
  logic [15:0] m_pos;
  bit          m_dir, m_err, m_inc, m_tick, adv, step, eset, acc_now;
  int          d;

  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    rawq = '{2'b00, 2'b00};
    hist.delete();
    nsamp = 0; en_edges = 0; delayed = 0; inc_seen = 0; tick_seen = 0;
    acc_pend = 0; tracking = 0; inc_next = 0;
    acc_val = 2'b00; last = 2'b00; m_pos = 16'h0;
    m_dir = 0; m_err = 0; m_inc = 0; m_tick = 0;
  endtask

  // Single compare process: advance the model on each edge, check all outputs 1 time unit later.
  always begin
    @(posedge CLK);
    raw = {ENC_A, ENC_B};
    if (wkctr_reset) begin
      model_reset();
    end else begin
      adv = EN && (((en_edges + 1) % SLOT) == 0);
      if (EN) en_edges++;
      m_tick = adv;

      step = 0; eset = 0;
      if (acc_pend) begin
        if (!tracking) tracking = 1;
        else begin
          d = (gpos(acc_val) - gpos(last) + 4) % 4;
          if (d == 1) begin m_pos = m_pos + 16'd1; m_dir = 1; step = 1; end
          else if (d == 3) begin m_pos = m_pos - 16'd1; m_dir = 0; step = 1; end
          else if (d == 2) eset = 1;
        end
        last = acc_val;
      end
      if (eset) m_err = 1;
      else if (ERR_CLR) m_err = 0;

      m_inc = EN && ((step && !adv) || inc_next);
      inc_next = EN && step && adv;
      if (inc_next) delayed++;

      s = rawq.pop_front();
      rawq.push_back(raw);
      hist.push_back(s);
      if (hist.size() > FL + 1) void'(hist.pop_front());
      nsamp++;
      acc_now = 0;
      if (nsamp >= FL) begin
        acc_now = 1;
        for (int i = 0; i < FL; i++)
          if (hist[hist.size() - 1 - i] != s) acc_now = 0;
        if (nsamp > FL && hist[0] == s) acc_now = 0;
      end
      acc_pend = acc_now;
      acc_val  = s;
    end
    #1;
    chk("INC", INC, m_inc);
    chk("DIR", DIR, m_dir);
    chk("SEL", SEL, 4'((en_edges / SLOT) % NSEL));
    chk("SLOT_TICK", SLOT_TICK, m_tick);
    chk("ERR", ERR, m_err);
    chk("POS", POS, m_pos);
    inc_seen  += int'(INC);
    tick_seen += int'(SLOT_TICK);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic [1:0] v);
    {ENC_A, ENC_B} = v;
  endtask

  task automatic do_reset(input logic [1:0] enc, input logic en);
    wkctr_reset = 1'b1;
    drive(enc);
    EN = en;
    cyc(2);
    wkctr_reset = 1'b0;
  endtask

  // Apply one step, measure raw-edge to POS-update latency, hold 10 cycles in total.
  task automatic step_lat(input logic [1:0] v, input logic [15:0] exp_pos, input string nm);
    int lat;
    lat = 0;
    drive(v);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (POS === exp_pos) begin
        lat = k;
        break;
      end
    end
    chk(nm, 32'(lat), 32'd7);
    if (lat > 0 && lat < 10) cyc(10 - lat);
  endtask

  logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  initial begin
    // 1: reset with encoder at 11, INIT absorbs the first level
    cyc(2);
    chk("rst_pos", POS, 16'h0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_sel", SEL, 4'h0);
    wkctr_reset = 1'b0;
    cyc(12);
    chk("t1_pos", POS, 16'h0);
    chk("t1_err", ERR, 1'b0);
    chk("t1_inc_cnt", 32'(inc_seen), 32'd0);
    step_lat(2'b10, 16'd1, "t1_lat");
    chk("t1_dir", DIR, 1'b1);

    // 2: forward sequence, 7-cycle latency per step
    do_reset(2'b00, 1'b1);
    cyc(10);
    step_lat(2'b01, 16'd1, "t2_lat1");
    step_lat(2'b11, 16'd2, "t2_lat2");
    step_lat(2'b10, 16'd3, "t2_lat3");
    step_lat(2'b00, 16'd4, "t2_lat4");
    chk("t2_pos", POS, 16'd4);
    chk("t2_dir", DIR, 1'b1);
    chk("t2_inc_cnt", 32'(inc_seen), 32'd4);

    // 3: short glitch rejected, then forward and reverse
    drive(2'b10); cyc(3); drive(2'b00); cyc(15);
    chk("t3_glitch_pos", POS, 16'd4);
    chk("t3_glitch_inc", 32'(inc_seen), 32'd4);
    drive(2'b01); cyc(10);
    chk("t3_fwd_pos", POS, 16'd5);
    drive(2'b00); cyc(10);
    chk("t3_rev_pos", POS, 16'd4);
    chk("t3_rev_dir", DIR, 1'b0);
    chk("t3_inc_cnt", 32'(inc_seen), 32'd6);

    // 5: illegal jump, clear, and clear colliding with a new illegal jump
    drive(2'b11); cyc(10);
    chk("t5_err_set", ERR, 1'b1);
    chk("t5_pos", POS, 16'd4);
    chk("t5_inc_cnt", 32'(inc_seen), 32'd6);
    ERR_CLR = 1'b1; cyc(1); ERR_CLR = 1'b0;
    chk("t5_err_clr", ERR, 1'b0);
    drive(2'b00); cyc(6);
    ERR_CLR = 1'b1; cyc(1); ERR_CLR = 1'b0;
    chk("t5_set_wins", ERR, 1'b1);
    cyc(5);

    // 6: EN=0 keeps tracking without INC, then reset mid-step
    EN = 1'b0;
    drive(2'b01); cyc(10);
    drive(2'b11); cyc(10);
    drive(2'b10); cyc(10);
    chk("t6_pos", POS, 16'd7);
    chk("t6_dir", DIR, 1'b1);
    chk("t6_inc_cnt", 32'(inc_seen), 32'd6);
    drive(2'b00); cyc(3);
    wkctr_reset = 1'b1;
    #1;
    chk("t6_rst_inc", INC, 1'b0);
    chk("t6_rst_dir", DIR, 1'b0);
    chk("t6_rst_sel", SEL, 4'h0);
    chk("t6_rst_tick", SLOT_TICK, 1'b0);
    chk("t6_rst_err", ERR, 1'b0);
    chk("t6_rst_pos", POS, 16'h0);
    drive(2'b11); EN = 1'b1;
    cyc(2);
    wkctr_reset = 1'b0;
    cyc(12);
    chk("t6_init_err", ERR, 1'b0);
    chk("t6_init_pos", POS, 16'h0);

    // 4: 128 enabled cycles, steps every 9 cycles so two land on SEL advances
    do_reset(2'b00, 1'b1);
    for (int i = 0; i < 14; i++) begin
      drive(gseq[i % 4]);
      cyc(9);
    end
    cyc(2);
    chk("t4_ticks", 32'(tick_seen), 32'd16);
    chk("t4_sel_wrap", SEL, 4'h0);
    chk("t4_pos", POS, 16'd13);
    chk("t4_inc_cnt", 32'(inc_seen), 32'd13);
    chk("t4_deferred", 32'(delayed), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
